// File: rtl/frac_blend_pkg.sv
// frac_blend_pkg: shared types and constants for the fractional RGB blender.
package frac_blend_pkg;

  localparam int PIPE_LATENCY   = 3;
  localparam int RGB_CHAN_BITS  = 6;

  typedef struct packed {
    logic [RGB_CHAN_BITS-1:0] r;
    logic [RGB_CHAN_BITS-1:0] g;
    logic [RGB_CHAN_BITS-1:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH0 = 2'd1,
    FETCH1 = 2'd2,
    RUN    = 2'd3
  } state_t;

endpackage

// File: rtl/frac_blend_mac.sv
// frac_blend_mac: one colour channel's weighted sum prev*(2^W-w) + curr*w.
// Defining FRAC_BLEND_ROUND_EN adds half an LSB of the weight so the later shift rounds half-up.
module frac_blend_mac #(
  parameter int colourbits = 6,
  parameter int weightbits = 4
) (
  input  logic [colourbits-1:0]            prev,
  input  logic [colourbits-1:0]            curr,
  input  logic [weightbits-1:0]            w,
  output logic [colourbits+weightbits-1:0] acc
);

  localparam int AW = colourbits + weightbits;

  logic [AW-1:0] p_ext;
  logic [AW-1:0] c_ext;
  logic [AW-1:0] w_ext;
  logic [AW-1:0] sum;

  // prev*(2^W - w) written as (prev << W) - prev*w keeps every term at AW bits;
  // the true result never exceeds AW bits, so modular intermediates are exact.
  always_comb begin
    p_ext = AW'(prev);
    c_ext = AW'(curr);
    w_ext = AW'(w);
    sum   = (p_ext << weightbits) - p_ext * w_ext + c_ext * w_ext;
`ifdef FRAC_BLEND_ROUND_EN
    sum   = sum + (AW'(1) << (weightbits - 1));
`else
    sum   = sum;
`endif
  end

  assign acc = sum;

endmodule

// File: rtl/frac_blend.sv
// frac_blend: linearly interpolated RGB between the two source pixels straddling the fractional position.
// Build option FRAC_BLEND_ROUND_EN selects round-half-up instead of truncation (same latency).
module frac_blend
  import frac_blend_pkg::*;
#(
  parameter int bitwidth   = 10,
  parameter int fracwidth  = 16,
  parameter int colourbits = 6,
  parameter int weightbits = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    line_start,
  output logic                    primed,
  input  logic                    pix_valid,
  input  logic                    step,
  input  logic [fracwidth-1:0]    fraction,
  input  logic                    blank,
  output logic [bitwidth-1:0]     rd_addr,
  input  logic [3*colourbits-1:0] rd_data,
  output logic                    out_valid,
  output logic [3*colourbits-1:0] out_rgb
);

  localparam int RGBW = 3 * colourbits;
  localparam int AW   = colourbits + weightbits;
  localparam logic [bitwidth-1:0] ADDR_MAX = '1;

  state_t                state_reg, state_next;
  logic [bitwidth-1:0]   addr_reg, addr_next, addr_inc;
  logic                  primed_reg, load_curr_reg;
  logic [RGBW-1:0]       prev_reg, curr_reg;
  logic [RGBW-1:0]       prev_op, curr_op, blended;
  logic                  accept, advance, window_shift;

  logic                  s0_valid_reg, s0_step_reg, s0_blank_reg;
  logic [weightbits-1:0] s0_w_reg;
  logic                  acc_valid_reg, acc_blank_reg;
  logic                  out_valid_reg;
  logic [RGBW-1:0]       out_rgb_reg;

  assign accept       = pix_valid & primed_reg & ~line_start;
  assign addr_inc     = addr_reg + bitwidth'(1);
  assign advance      = accept & step & (addr_reg != ADDR_MAX);
  assign window_shift = s0_valid_reg & s0_step_reg;

  // The address moves in the request cycle itself so the new pixel is back from the
  // registered RAM exactly when the request reaches the window stage.
  assign rd_addr = advance ? addr_inc : addr_reg;

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    if (line_start) begin
      state_next = FETCH0;
      addr_next  = '0;
    end else begin
      case (state_reg)
        IDLE:    state_next = IDLE;
        FETCH0: begin
          state_next = FETCH1;
          addr_next  = bitwidth'(1);
        end
        FETCH1:  state_next = RUN;
        RUN:     if (advance) addr_next = addr_inc;
        default: state_next = IDLE;
      endcase
    end
  end

  // primed rises on entering RUN; curr is filled on that first RUN cycle via load_curr_reg.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      primed_reg    <= 1'b0;
      load_curr_reg <= 1'b0;
      prev_reg      <= '0;
      curr_reg      <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      if (line_start) begin
        primed_reg    <= 1'b0;
        load_curr_reg <= 1'b0;
      end else if (state_reg == FETCH1) begin
        prev_reg      <= rd_data;
        primed_reg    <= 1'b1;
        load_curr_reg <= 1'b1;
      end else if (load_curr_reg) begin
        curr_reg      <= rd_data;
        load_curr_reg <= 1'b0;
      end else if (window_shift) begin
        prev_reg <= curr_reg;
        curr_reg <= rd_data;
      end
    end
  end

  // A stepping request blends the pair it just moved onto, not the stale one.
  assign prev_op = window_shift ? curr_reg : prev_reg;
  assign curr_op = window_shift ? rd_data  : curr_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_valid_reg  <= 1'b0;
      s0_step_reg   <= 1'b0;
      s0_blank_reg  <= 1'b0;
      s0_w_reg      <= '0;
      acc_valid_reg <= 1'b0;
      acc_blank_reg <= 1'b0;
      out_valid_reg <= 1'b0;
      out_rgb_reg   <= '0;
    end else begin
      s0_valid_reg <= accept;
      if (accept) begin
        s0_w_reg     <= weightbits'(fraction >> (fracwidth - weightbits));
        s0_step_reg  <= step;
        s0_blank_reg <= blank;
      end
      acc_valid_reg <= s0_valid_reg & ~line_start;
      acc_blank_reg <= s0_blank_reg;
      out_valid_reg <= acc_valid_reg & ~line_start;
      if (acc_valid_reg) out_rgb_reg <= acc_blank_reg ? '0 : blended;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic [AW-1:0] mac_acc;
      logic [AW-1:0] acc_reg;

      frac_blend_mac #(
        .colourbits(colourbits),
        .weightbits(weightbits)
      ) u_mac (
        .prev(prev_op[gi*colourbits +: colourbits]),
        .curr(curr_op[gi*colourbits +: colourbits]),
        .w   (s0_w_reg),
        .acc (mac_acc)
      );

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          acc_reg <= '0;
        else if (s0_valid_reg) acc_reg <= mac_acc;
      end

      assign blended[gi*colourbits +: colourbits] = colourbits'(acc_reg >> weightbits);
    end
  endgenerate

  assign primed    = primed_reg;
  assign out_valid = out_valid_reg;
  assign out_rgb   = out_rgb_reg;

endmodule

// File: tb/tb_frac_blend.sv
// tb_frac_blend: randomized and directed stimulus checked against an index-based blend model.
module tb_frac_blend;
  import frac_blend_pkg::*;

  localparam int BW   = 10;
  localparam int FW   = 16;
  localparam int CB   = 6;
  localparam int WB   = 4;
  localparam int RGBW = 3 * CB;
  localparam int LAST = (1 << BW) - 1;
`ifdef FRAC_BLEND_ROUND_EN
  localparam int ROUND_ADD = 1 << (WB - 1);
`else
  localparam int ROUND_ADD = 0;
`endif

  logic clk = 1'b0, reset_n = 1'b0;
  logic line_start = 1'b0, pix_valid = 1'b0, step = 1'b0, blank = 1'b0;
  logic [FW-1:0]   fraction = '0;
  logic            primed, out_valid;
  logic [BW-1:0]   rd_addr;
  logic [RGBW-1:0] rd_data, out_rgb;

  logic [RGBW-1:0] mem [1 << BW];

  int tests = 0, fails = 0, cyc = 0;
  int line_cyc = -1, prev_idx = 0, curr_idx = 1;

  typedef struct { int due; logic [RGBW-1:0] rgb; } exp_t;
  exp_t expq[$];

  frac_blend #(.bitwidth(BW), .fracwidth(FW), .colourbits(CB), .weightbits(WB)) dut (
    .clk(clk), .reset_n(reset_n), .line_start(line_start), .primed(primed),
    .pix_valid(pix_valid), .step(step), .fraction(fraction), .blank(blank),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_rgb(out_rgb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_data <= mem[rd_addr];
    cyc     <= cyc + 1;
  end

  function automatic int blend(int p, int c, int w);
    int a;
    a = p * ((1 << WB) - w) + c * w + ROUND_ADD;
    return a / (1 << WB);
  endfunction

  function automatic logic [RGBW-1:0] exp_pix(int pi, int ci, int w, logic bl);
    logic [RGBW-1:0] p, c, r;
    p = mem[pi];
    c = mem[ci];
    r = '0;
    if (!bl)
      for (int ch = 0; ch < 3; ch++)
        r[ch*CB +: CB] = CB'(blend(int'(p[ch*CB +: CB]), int'(c[ch*CB +: CB]), w));
    return r;
  endfunction

  function automatic logic [RGBW-1:0] rgb3(int v);
    return {CB'(v), CB'(v), CB'(v)};
  endfunction

  function automatic bit model_primed();
    return line_cyc >= 0 && cyc >= line_cyc + 3;
  endfunction

  function automatic int exp_addr();
    if (line_cyc < 0) return 0;
    if (cyc == line_cyc + 1) return 0;
    return curr_idx;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of upstream signals, advance the model, then sit at the falling edge.
  task automatic one(input logic ls, input logic pv, input logic st, input logic bl, input logic [FW-1:0] fr);
    @(posedge clk); #1;
    line_start = ls; pix_valid = pv; step = st; blank = bl; fraction = fr;
    if (ls) begin
      line_cyc = cyc; prev_idx = 0; curr_idx = 1;
      while (expq.size() > 0 && expq[$].due > cyc) void'(expq.pop_back());
    end else if (pv && model_primed()) begin
      if (st) begin
        prev_idx = curr_idx;
        if (curr_idx < LAST) curr_idx++;
      end
      expq.push_back('{due: cyc + PIPE_LATENCY, rgb: exp_pix(prev_idx, curr_idx, int'(fr >> (FW - WB)), bl)});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) one(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic start_line();
    one(1'b1, 1'b0, 1'b0, 1'b0, '0);
    idle(2);
  endtask

  task automatic req_lit(input string name, input logic st, input logic bl, input logic [FW-1:0] fr,
                         input logic [RGBW-1:0] exp);
    one(1'b0, 1'b1, st, bl, fr);
    idle(3);
    chk({name, "_valid"}, out_valid, 1);
    chk(name, out_rgb, exp);
  endtask

  always @(negedge clk) begin
    logic            exp_v;
    logic [RGBW-1:0] exp_rgb;
    exp_v   = 1'b0;
    exp_rgb = '0;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      exp_v   = 1'b1;
      exp_rgb = expq[0].rgb;
      void'(expq.pop_front());
    end
    if (exp_v || out_valid)
      $display("[TB] cyc=%0d out_valid=%0b out_rgb=%h want_valid=%0b want_rgb=%h",
               cyc, out_valid, out_rgb, exp_v, exp_rgb);
    chk("out_valid", out_valid, exp_v);
    if (exp_v) chk("out_rgb", out_rgb, exp_rgb);
    if (!line_start) chk("primed", primed, model_primed());
    if (!line_start && !pix_valid) chk("rd_addr", rd_addr, exp_addr());
  end

  initial begin
    for (int i = 0; i <= LAST; i++) mem[i] = RGBW'($urandom);
    mem[0] = rgb3(8); mem[1] = rgb3(24); mem[2] = rgb3(40);

    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_rgb", out_rgb, 0);
    chk("reset_primed", primed, 0);
    chk("reset_rd_addr", rd_addr, 0);
    @(posedge clk); #1; reset_n = 1'b1;

    chk("model_mid", blend(8, 24, 8), 16);
    chk("model_w0", blend(24, 40, 0), 24);
    chk("model_wmax", blend(24, 40, 15), 39);
    chk("model_round", blend(0, 1, 15), (ROUND_ADD != 0) ? 1 : 0);

    // Line 1: midpoint, stepping blend, then a sustained burst
    start_line();
    req_lit("mid", 1'b0, 1'b0, 16'h8000, rgb3(16));
    req_lit("step", 1'b1, 1'b0, 16'h0000, rgb3(24));
    chk("step_addr", rd_addr, 2);
    for (int i = 0; i < 11; i++) begin
      one(1'b0, i < 8, 1'b0, 1'b0, 16'hF000);
      if (i >= 3) begin
        chk("burst_valid", out_valid, 1);
        chk("burst_rgb", out_rgb, rgb3(39));
      end
    end
    idle(1);
    chk("burst_end", out_valid, 0);

    // line_start colliding with a request mid-line flushes everything in flight
    one(1'b0, 1'b1, 1'b0, 1'b0, 16'h4000);
    one(1'b0, 1'b1, 1'b1, 1'b0, 16'h4000);
    one(1'b1, 1'b1, 1'b1, 1'b0, 16'h4000);
    for (int i = 1; i <= 3; i++) begin
      idle(1);
      chk("flush_valid", out_valid, 0);
      if (i == 1) chk("refetch_addr0", rd_addr, 0);
      if (i == 2) chk("refetch_addr1", rd_addr, 1);
      if (i == 3) chk("reprimed", primed, 1);
    end

    // Rounding pair, unprimed request, blanked step
    mem[0] = rgb3(0); mem[1] = rgb3(1); mem[2] = rgb3(40);
    one(1'b1, 1'b0, 1'b0, 1'b0, '0);
    one(1'b0, 1'b1, 1'b1, 1'b0, 16'h1234);
    idle(1);
    req_lit("round", 1'b0, 1'b0, 16'hF000, rgb3((ROUND_ADD != 0) ? 1 : 0));
    req_lit("blank", 1'b1, 1'b1, 16'h0000, rgb3(0));
    req_lit("after_blank", 1'b0, 1'b0, 16'h0000, rgb3(1));

    // Saturation at the last source pixel
    for (int i = 0; i <= LAST; i++) mem[i] = RGBW'($urandom);
    start_line();
    for (int i = 0; i < LAST + 8; i++)
      one(1'b0, 1'b1, 1'b1, ($urandom_range(0, 7) == 0), FW'($urandom));
    idle(4);
    chk("sat_addr", rd_addr, LAST);

    // Randomized traffic including stray line_starts
    for (int i = 0; i <= LAST; i++) mem[i] = RGBW'($urandom);
    start_line();
    for (int i = 0; i < 1500; i++)
      one(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
          ($urandom_range(0, 7) == 0), FW'($urandom));
    idle(4);

    // Asynchronous reset in the middle of a busy line
    start_line();
    for (int i = 0; i < 4; i++) one(1'b0, 1'b1, 1'b1, 1'b0, FW'($urandom));
    @(posedge clk); #1;
    reset_n = 1'b0; pix_valid = 1'b1; step = 1'b1; line_start = 1'b0;
    line_cyc = -1;
    expq.delete();
    #1;
    chk("mid_reset_out_valid", out_valid, 0);
    chk("mid_reset_out_rgb", out_rgb, 0);
    chk("mid_reset_primed", primed, 0);
    chk("mid_reset_rd_addr", rd_addr, 0);
    @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1; pix_valid = 1'b0; step = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) one(1'b0, 1'b1, 1'b0, 1'b0, 16'h8000);
    start_line();
    for (int i = 0; i < 6; i++) one(1'b0, 1'b1, $urandom_range(0, 1), 1'b0, FW'($urandom));
    idle(5);
    chk("drain", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
